// File: rtl/st7735s_spi_tx.sv
// st7735s_spi_tx: write-only 4-wire SPI byte transmitter (mode 0, MSB first)
// for an ST7735S LCD controller. One byte per handshake, flagged command/data
// on the D/C line. All outputs are registered.
//
// Build option: define ST7735S_SS_GAP_EN to insert a GAP state after HOLD that
// keeps CSX high (and o_waiting low) for one extra half-bit period, so that
// consecutive bytes are always separated by a CSX-high pulse.
module st7735s_spi_tx #(
    parameter int c_CLOCK_PER_SPI_HALF_BIT = 50
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_ncommand,
    input  logic [7:0] i_data,
    input  logic       i_data_rdy,
    output logic       o_waiting,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    output logic       o_spi_dc,
    output logic       o_spi_ss
);

    localparam int c_N     = c_CLOCK_PER_SPI_HALF_BIT;
    localparam int c_CNT_W = $clog2(c_N) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } t_state;

    t_state             r_state;
    t_state             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               r_waiting;
    logic               w_waiting_next;
    logic               r_sck;
    logic               w_sck_next;
    logic               r_mosi;
    logic               w_mosi_next;
    logic               r_dc;
    logic               w_dc_next;
    logic               r_ss;
    logic               w_ss_next;

    assign o_waiting  = r_waiting;
    assign o_spi_clk  = r_sck;
    assign o_spi_mosi = r_mosi;
    assign o_spi_dc   = r_dc;
    assign o_spi_ss   = r_ss;

    // State and output registers; reset aborts any byte in flight immediately.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_waiting <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_dc      <= 1'b0;
            r_ss      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_shift   <= w_shift_next;
            r_waiting <= w_waiting_next;
            r_sck     <= w_sck_next;
            r_mosi    <= w_mosi_next;
            r_dc      <= w_dc_next;
            r_ss      <= w_ss_next;
        end
    end

    // Next-state and next-output logic; every phase lasts c_N cycles, timed by r_cnt.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit;
        w_shift_next   = r_shift;
        w_waiting_next = r_waiting;
        w_sck_next     = r_sck;
        w_mosi_next    = r_mosi;
        w_dc_next      = r_dc;
        w_ss_next      = r_ss;

        case (r_state)
            ST_IDLE: begin
                // o_waiting comes up one cycle after reset release; a strobe is
                // only honoured once o_waiting is already visible.
                w_waiting_next = 1'b1;
                w_ss_next      = 1'b1;
                w_sck_next     = 1'b0;
                w_mosi_next    = 1'b0;
                w_cnt_next     = '0;
                if (r_waiting && i_data_rdy) begin
                    w_state_next   = ST_SETUP;
                    w_shift_next   = i_data;
                    w_dc_next      = i_ncommand;
                    w_waiting_next = 1'b0;
                    w_ss_next      = 1'b0;
                    w_mosi_next    = i_data[7];
                    w_bit_next     = 3'd7;
                end
            end

            ST_SETUP: begin
                // MOSI already carries bit 7; give it a full half-period of setup.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                    w_sck_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end

            ST_HIGH: begin
                // Falling SCK edge: present the next bit (or 0 after bit 0).
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_sck_next   = 1'b0;
                    w_shift_next = {r_shift[6:0], 1'b0};
                    w_bit_next   = r_bit - 3'd1;
                    if (r_bit == 3'd0) begin
                        w_state_next = ST_HOLD;
                        w_mosi_next  = 1'b0;
                    end else begin
                        w_state_next = ST_LOW;
                        w_mosi_next  = r_shift[6];
                    end
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end

            ST_LOW: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next = ST_HIGH;
                    w_cnt_next   = '0;
                    w_sck_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end

            ST_HOLD: begin
                // Low half of bit 0 with CSX still asserted, then release CSX.
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_next = '0;
                    w_ss_next  = 1'b1;
`ifdef ST7735S_SS_GAP_EN
                    w_state_next   = ST_GAP;
                    w_waiting_next = 1'b0;
`else
                    w_state_next   = ST_IDLE;
                    w_waiting_next = 1'b1;
`endif
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end

`ifdef ST7735S_SS_GAP_EN
            ST_GAP: begin
                // Guaranteed CSX-high interval before the next byte may start.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_next   = ST_IDLE;
                    w_cnt_next     = '0;
                    w_waiting_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
`endif

            default: begin
                w_state_next   = ST_IDLE;
                w_cnt_next     = '0;
                w_waiting_next = 1'b0;
                w_sck_next     = 1'b0;
                w_mosi_next    = 1'b0;
                w_ss_next      = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_st7735s_spi_tx.sv
// Directed testbench for st7735s_spi_tx (N = 50). Each transfer is watched
// cycle by cycle: SCK rising-edge MOSI samples, SCK half-period lengths,
// CSX/DC framing and handshake latency are compared with hand-computed values.
module tb_st7735s_spi_tx;

    localparam int N = 50;
`ifdef ST7735S_SS_GAP_EN
    localparam int LAT  = 18 * N + 1;
    localparam int GAP  = N;
    localparam int TAIL = N + 1;
`else
    localparam int LAT  = 17 * N + 1;
    localparam int GAP  = 0;
    localparam int TAIL = 1;
`endif

    logic       clk;
    logic       nrst;
    logic       ncommand;
    logic [7:0] data;
    logic       data_rdy;
    logic       waiting;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_dc;
    logic       spi_ss;

    int checks;
    int errors;

    st7735s_spi_tx #(.c_CLOCK_PER_SPI_HALF_BIT(N)) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_ncommand (ncommand),
        .i_data     (data),
        .i_data_rdy (data_rdy),
        .o_waiting  (waiting),
        .o_spi_clk  (spi_clk),
        .o_spi_mosi (spi_mosi),
        .o_spi_dc   (spi_dc),
        .o_spi_ss   (spi_ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one byte and monitors it until o_waiting rises. Called and returns
    // at 1 time unit after a rising clock edge. intr_at > 1 injects a strobe
    // of 0x3C (data) at that cycle of the busy transfer.
    task automatic xfer(input string name, input logic [7:0] d, input logic ncmd,
                        input logic [7:0] exp_bits, input logic exp_dc,
                        input int intr_at, output int tail);
        int   w;
        int   cyc;
        int   rises;
        int   bad_runs;
        int   run;
        int   ss_low;
        int   gap_cnt;
        int   dc_bad;
        int   tl;
        logic prev;
        logic mosi_b0;
        logic [7:0] bits;
        w = 0;
        while (waiting !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        check({name, " ready"}, waiting, 1'b1);
        data = d; ncommand = ncmd; data_rdy = 1'b1;
        cyc = 0; rises = 0; bad_runs = 0; run = 0; ss_low = 0; gap_cnt = 0;
        dc_bad = 0; tl = 0; prev = 1'b0; mosi_b0 = 1'b1; bits = 8'h00;
        do begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) begin
                data_rdy = 1'b0; data = ~d; ncommand = ~ncmd;
            end
            if (intr_at > 1 && cyc == intr_at) begin
                data = 8'h3C; ncommand = 1'b1; data_rdy = 1'b1;
            end else if (intr_at > 1 && cyc == intr_at + 1) begin
                data_rdy = 1'b0;
            end
            if (spi_clk !== prev) begin
                if (run != N) bad_runs++;
                if (spi_clk === 1'b1) begin
                    rises++;
                    bits = {bits[6:0], spi_mosi};
                end else if (rises == 8) begin
                    mosi_b0 = spi_mosi;
                end
                run = 1;
            end else begin
                run++;
            end
            prev = spi_clk;
            if (spi_ss === 1'b0) begin
                ss_low++; tl = 0;
                if (spi_dc !== exp_dc) dc_bad++;
            end else begin
                tl++;
            end
            if (spi_ss === 1'b1 && waiting === 1'b0) gap_cnt++;
        end while (waiting !== 1'b1 && cyc < 2000);
        tail = tl;
        check({name, " latency"}, cyc, LAT);
        check({name, " mosi bits"}, bits, exp_bits);
        check({name, " sck rises"}, rises, 8);
        check({name, " half-period errors"}, bad_runs, 0);
        check({name, " mosi after bit0"}, mosi_b0, 1'b0);
        check({name, " ss low cycles"}, ss_low, 17 * N);
        check({name, " dc errors"}, dc_bad, 0);
        check({name, " gap cycles"}, gap_cnt, GAP);
        check({name, " ss end"}, spi_ss, 1'b1);
        check({name, " dc held"}, spi_dc, exp_dc);
        check({name, " sck end"}, spi_clk, 1'b0);
        $display("xfer %s: data=%02h ncmd=%0d bits=%02h cycles=%0d dc=%0d", name, d, ncmd, bits, cyc, spi_dc);
    endtask

    initial begin
        int   tail;
        int   edges;
        int   cyc;
        logic prev;
        checks = 0; errors = 0;
        nrst = 1'b0; ncommand = 1'b0; data = 8'h00; data_rdy = 1'b0;

        // 1: reset values and waiting one cycle after release
        repeat (10) @(posedge clk);
        #1;
        check("rst ss", spi_ss, 1'b1);
        check("rst sck", spi_clk, 1'b0);
        check("rst mosi", spi_mosi, 1'b0);
        check("rst dc", spi_dc, 1'b0);
        check("rst waiting", waiting, 1'b0);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("rel waiting", waiting, 1'b1);
        $display("reset released, waiting=%0d", waiting);

        // 2: command 0x95
        xfer("cmd95", 8'h95, 1'b0, 8'b1001_0101, 1'b0, 0, tail);

        // 3: data 0xA5
        xfer("dataA5", 8'hA5, 1'b1, 8'b1010_0101, 1'b1, 0, tail);

        // 4: strobe 0x3C while 0x95 is busy is dropped
        xfer("busy95", 8'h95, 1'b0, 8'b1001_0101, 1'b0, 200, tail);
        repeat (5) @(posedge clk);
        #1;
        check("busy no requeue waiting", waiting, 1'b1);
        check("busy no requeue ss", spi_ss, 1'b1);

        // 5: asynchronous reset after 4 SCK edges of 0xFF
        data = 8'hFF; ncommand = 1'b1; data_rdy = 1'b1;
        @(posedge clk); #1;
        data_rdy = 1'b0;
        edges = 0; cyc = 0; prev = 1'b0;
        while (edges < 4 && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
            if (spi_clk !== prev) edges++;
            prev = spi_clk;
        end
        check("abort edges", edges, 4);
        check("abort pre ss", spi_ss, 1'b0);
        check("abort pre mosi", spi_mosi, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check("abort ss", spi_ss, 1'b1);
        check("abort sck", spi_clk, 1'b0);
        check("abort mosi", spi_mosi, 1'b0);
        check("abort dc", spi_dc, 1'b0);
        check("abort waiting", waiting, 1'b0);
        $display("reset asserted mid-byte after %0d sck edges", edges);
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;
        check("abort rel waiting", waiting, 1'b1);
        xfer("cmd5A", 8'h5A, 1'b0, 8'b0101_1010, 1'b0, 0, tail);

        // 6: back-to-back 0x2A command then 0x00 data
        xfer("cmd2A", 8'h2A, 1'b0, 8'b0010_1010, 1'b0, 0, tail);
        check("b2b ss high between", tail, TAIL);
        xfer("data00", 8'h00, 1'b1, 8'b0000_0000, 1'b1, 0, tail);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
